// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared FSM encoding and default geometry for the RAM-backed FIFO controller.
package ram_fifo_pkg;
    localparam int default_data_width = 8;
    localparam int default_addr_width = 3;
    localparam int default_depth      = 2 ** default_addr_width;
    typedef enum logic {st_idle, st_read_wait} state_t;
endpackage

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrapping address counter with increment enable and async active-low clear.
module ram_fifo_ptr #(
    parameter int width = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [width-1:0] ptr
);
    always_ff @(posedge clock or negedge reset)
        if (!reset) ptr <= '0;
        else if (inc) ptr <= ptr + width'(1);
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port synchronous RAM into a valid/ready FIFO with a one-entry output register.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int addr_width = default_addr_width
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_di,
    input  logic [data_width-1:0] ram_do,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam logic [addr_width:0] full_level = {1'b1, {addr_width{1'b0}}};
    state_t state, state_nxt;
    logic [addr_width-1:0] wr_ptr, rd_ptr;
    logic rd_issue, wr_fire;
    assign full     = count == full_level;
    assign rd_issue = state == st_idle && !out_valid && count != '0;
    assign wr_fire  = in_valid && in_ready;
    assign empty    = count == '0 && state != st_read_wait && !out_valid;
    assign ram_di   = in_data;
    ram_fifo_ptr #(.width(addr_width)) u_wr_ptr (
        .clock(clock), .reset(reset), .inc(wr_fire), .ptr(wr_ptr)
    );
    ram_fifo_ptr #(.width(addr_width)) u_rd_ptr (
        .clock(clock), .reset(reset), .inc(rd_issue), .ptr(rd_ptr)
    );
    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= st_idle;
        else state <= state_nxt;
    always_comb
        state_nxt = state == st_read_wait ? st_idle : rd_issue ? st_read_wait : st_idle;
    // Reads take priority; reset gates in_ready so nothing is accepted while held.
    always_comb begin
        in_ready = !full && !rd_issue && reset;
        ram_en   = rd_issue || wr_fire;
        ram_we   = !rd_issue && wr_fire;
        ram_addr = rd_issue ? rd_ptr : wr_ptr;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (rd_issue) count <= count - (addr_width + 1)'(1);
        else if (wr_fire) count <= count + (addr_width + 1)'(1);
    // The read issued last edge returns now; reload can't collide with a consume.
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == st_read_wait) begin
            out_valid <= 1'b1;
            out_data  <= ram_do;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: controller plus behavioural RAM, checked against a queue-level model.
module tb_ram_fifo_ctrl;
    logic       clock = 0, reset = 0;
    logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
    logic [7:0] in_data = 0, out_data, ram_di, ram_do;
    logic       ram_en, ram_we, full, empty;
    logic [2:0] ram_addr;
    logic [3:0] count;
    logic [7:0] mem [8];
    int checks = 0, errors = 0;
    logic [7:0] ramq[$], sent[$], got[$];
    logic       fl_v = 0, ov = 0;
    logic [7:0] fl_d = 0, od = 0;
    logic [2:0] wa = 0, ra = 0;

    ram_fifo_ctrl dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_di;
            else ram_do <= mem[ram_addr];
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words in RAM, one in-flight read, output register; a read starts whenever
    // nothing is in flight, the output register is free and RAM holds a word.
    always @(negedge clock) begin
        logic issue, rdy, fire;
        if (!reset) begin
            ramq.delete();
            fl_v = 0; ov = 0; od = 0; wa = 0; ra = 0;
        end
        issue = reset && !fl_v && !ov && ramq.size() != 0;
        rdy   = reset && ramq.size() < 8 && !issue;
        fire  = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, ov);
        chk("out_data", out_data, od);
        chk("count", count, ramq.size());
        chk("full", full, ramq.size() == 8);
        chk("empty", empty, ramq.size() == 0 && !fl_v && !ov);
        chk("ram_en", ram_en, issue || fire);
        chk("ram_we", ram_we, fire);
        chk("ram_addr", ram_addr, issue ? ra : wa);
        if (fire) chk("ram_di", ram_di, in_data);
        if (ov && out_ready) got.push_back(od);
        if (reset) begin
            if (ov && out_ready) ov = 0;
            if (fl_v) begin ov = 1; od = fl_d; fl_v = 0; end
            if (issue) begin fl_v = 1; fl_d = ramq.pop_front(); ra++; end
            if (fire) begin ramq.push_back(in_data); sent.push_back(in_data); wa++; end
        end
    end

    task automatic push(input logic [7:0] d);
        int n = 0;
        in_valid = 1; in_data = d;
        do begin @(negedge clock); n++; end while (!in_ready && n < 100);
        if (!in_ready) chk("push_timeout", 0, 1);
        @(posedge clock); #1 in_valid = 0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 0;
        @(posedge clock); #1 reset = 1;
    endtask

    initial begin
        #200000 $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ram_addr", ram_addr, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1;
        // three words, consumer stalled
        push(3); push(5); push(7);
        chk("t1_count", count, 2);
        chk("t1_out_data", out_data, 3);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_empty", empty, 0);
        // fill RAM plus output register
        do_reset();
        for (int i = 0; i < 9; i++) push(8'(i));
        chk("t2_full", full, 1);
        chk("t2_count", count, 8);
        chk("t2_in_ready", in_ready, 0);
        chk("t2_out_data", out_data, 0);
        in_valid = 1; in_data = 9;
        repeat (5) begin @(negedge clock); chk("t2_held", in_ready, 0); end
        // drain through the pointer wrap, pending word follows
        got.delete();
        @(posedge clock); #1 out_ready = 1;
        push(9);
        repeat (40) @(posedge clock);
        #1 chk("t3_got_size", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++) chk("t3_order", got[i], i);
        chk("t3_empty", empty, 1);
        // single word latency
        out_ready = 0;
        push(8'hA5);
        @(negedge clock); chk("t4_n1", out_valid, 0);
        @(negedge clock); chk("t4_n2", out_valid, 0);
        @(negedge clock); chk("t4_n3", out_valid, 1);
        chk("t4_data", out_data, 8'hA5);
        @(posedge clock); #1 out_ready = 1;
        repeat (3) @(posedge clock);
        #1 chk("t4_empty", empty, 1);
        // random traffic
        got.delete(); sent.delete();
        for (int i = 0; i < 500; i++) begin
            @(posedge clock); #1;
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 0; out_ready = 1;
        repeat (40) @(posedge clock);
        #1 chk("t5_size", got.size(), sent.size());
        for (int i = 0; i < got.size() && i < sent.size(); i++)
            if (got[i] !== sent[i]) chk("t5_order", got[i], sent[i]);
        chk("t5_empty", empty, 1);
        // reset during a read with four words stored
        out_ready = 0;
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
        out_ready = 1;
        @(posedge clock); #1 out_ready = 0;
        @(posedge clock); #2;
        chk("t6_pre_count", count, 4);
        chk("t6_pre_valid", out_valid, 0);
        reset = 0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_empty", empty, 1);
        @(posedge clock); #1 reset = 1;
        in_valid = 1; in_data = 8'h3C;
        @(negedge clock);
        chk("t6_we", ram_we, 1);
        chk("t6_addr", ram_addr, 0);
        @(posedge clock); #1 in_valid = 0;
        repeat (4) @(posedge clock);
        #1 chk("t6_data", out_data, 8'h3C);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
